boot_copy_master: RTL and testbench

BOOT_COPY_MASTER -- requirements
Module: boot_copy_master

---
 rtl/boot_copy_master_if.sv | 28 ++
 rtl/boot_copy_master.sv | 162 ++++++++++++++++
 tb/tb_boot_copy_master.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copy_master_if.sv
// Avalon-MM master bus bundle used by the boot copy engine.
// Signal names follow the block's published port names so traces map one-to-one.
interface boot_copy_master_if;
    logic [29:0] o_AV_Addr;
    logic        o_AV_Read;
    logic        o_AV_Write;
    logic [31:0] o_AV_WriteData;
    logic [31:0] i_AV_ReadData;
    logic        i_AV_WaitRequest;

    modport master (
        output o_AV_Addr,
        output o_AV_Read,
        output o_AV_Write,
        output o_AV_WriteData,
        input  i_AV_ReadData,
        input  i_AV_WaitRequest
    );

    modport slave (
        input  o_AV_Addr,
        input  o_AV_Read,
        input  o_AV_Write,
        input  o_AV_WriteData,
        output i_AV_ReadData,
        output i_AV_WaitRequest
    );
endinterface

// File: rtl/boot_copy_master.sv
// Word-by-word memory copy engine: read one word, capture it, write it, repeat.
// Every output comes straight from a register; the bus fields hold while the slave stalls.
module boot_copy_master #(
    parameter int LEN_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    input  logic [29:0]         i_SrcAddr,
    input  logic [29:0]         i_DstAddr,
    input  logic [LEN_BITS-1:0] i_Len,
    output logic                o_Busy,
    output logic                o_Done,
    boot_copy_master_if.master  av
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam logic [LEN_BITS-1:0] LEN_ZERO = {LEN_BITS{1'b0}};
    localparam logic [LEN_BITS-1:0] LEN_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};

    state_t              state_r, state_s;
    logic [29:0]         src_r, src_s;
    logic [29:0]         dst_r, dst_s;
    logic [LEN_BITS-1:0] count_r, count_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [29:0]         addr_r, addr_s;
    logic                read_r, read_s;
    logic                write_r, write_s;
    logic [31:0]         wdata_r, wdata_s;

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r <= ST_IDLE;
            src_r   <= 30'd0;
            dst_r   <= 30'd0;
            count_r <= LEN_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            addr_r  <= 30'd0;
            read_r  <= 1'b0;
            write_r <= 1'b0;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            count_r <= count_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            addr_r  <= addr_s;
            read_r  <= read_s;
            write_r <= write_s;
            wdata_r <= wdata_s;
        end
    end

    // Next-state and next-output logic; anything not assigned below simply holds.
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        count_s = count_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        addr_s  = addr_r;
        read_s  = read_r;
        write_s = write_r;
        wdata_s = wdata_r;

        case (state_r)
            ST_IDLE: begin
                if (i_Start) begin
                    src_s   = i_SrcAddr;
                    dst_s   = i_DstAddr;
                    count_s = i_Len;
                    busy_s  = 1'b1;
                    if (i_Len == LEN_ZERO) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_READ;
                        read_s  = 1'b1;
                        addr_s  = i_SrcAddr;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_READ: begin
                if (!av.i_AV_WaitRequest) begin
                    read_s  = 1'b0;
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_READ;
                end
            end

            // The slave returns data exactly one cycle after accepting the read.
            ST_CAPTURE: begin
                wdata_s = av.i_AV_ReadData;
                write_s = 1'b1;
                addr_s  = dst_r;
                state_s = ST_WRITE;
            end

            ST_WRITE: begin
                if (!av.i_AV_WaitRequest) begin
                    write_s = 1'b0;
                    src_s   = src_r + 30'd1;
                    dst_s   = dst_r + 30'd1;
                    count_s = count_r - LEN_ONE;
                    if (count_r == LEN_ONE) begin
                        state_s = ST_FINISH;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_READ;
                        read_s  = 1'b1;
                        addr_s  = src_r + 30'd1;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end

            // A zero-length copy arrives here with done still low and pulses it one cycle later.
            ST_FINISH: begin
                if (done_r) begin
                    state_s = ST_IDLE;
                end else begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_FINISH;
                end
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                read_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    assign o_Busy            = busy_r;
    assign o_Done            = done_r;
    assign av.o_AV_Addr      = addr_r;
    assign av.o_AV_Read      = read_r;
    assign av.o_AV_Write     = write_r;
    assign av.o_AV_WriteData = wdata_r;

endmodule

// File: tb/tb_boot_copy_master.sv
// Self-checking bench: a stalling memory slave, a transaction monitor and a copy-level model.
module tb_boot_copy_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [29:0] src_in = 30'd0;
    logic [29:0] dst_in = 30'd0;
    logic [15:0] len_in = 16'd0;
    logic        busy;
    logic        done;

    boot_copy_master_if av ();

    boot_copy_master #(.LEN_BITS(16)) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_Start   (start),
        .i_SrcAddr (src_in),
        .i_DstAddr (dst_in),
        .i_Len     (len_in),
        .o_Busy    (busy),
        .o_Done    (done),
        .av        (av)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor / slave state
    int          tb_cyc = 0;
    int          wait_cycles = 0;
    int          stall_cnt = 0;
    logic        pend_v = 1'b0;
    logic [31:0] pend_d = 32'd0;
    logic        prev_stall = 1'b0;
    logic [63:0] snap = 64'd0;
    int          stab_err = 0;
    int          both_err = 0;
    int          req_cycles = 0;
    int          busy_cycles = 0;
    int          done_cycles = 0;
    int          done_at = -1;
    logic [29:0] rd_q[$];
    logic [61:0] wr_q[$];

    // Source memory contents: a small boot ROM at 0..3, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        case (a)
            30'd0:   mem_word = 32'h800000B7;
            30'd1:   mem_word = 32'h00000113;
            30'd2:   mem_word = 32'h0000A183;
            30'd3:   mem_word = 32'h00312023;
            default: mem_word = {a, 2'b01} ^ 32'hC3A55A3C;
        endcase
    endfunction

    always @(posedge clk) tb_cyc++;

    // Slave and monitor: decide the stall for this cycle, then log what the next edge accepts.
    always @(negedge clk) begin
        if (!rst_n) begin
            av.i_AV_WaitRequest = 1'b0;
            av.i_AV_ReadData    = 32'd0;
            stall_cnt  = 0;
            pend_v     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({av.o_AV_Addr, av.o_AV_Read, av.o_AV_Write, av.o_AV_WriteData} !== snap))
                stab_err++;
            if (av.o_AV_Read && av.o_AV_Write) both_err++;
            av.i_AV_ReadData = pend_v ? pend_d : $urandom();
            pend_v = 1'b0;
            if (av.o_AV_Read || av.o_AV_Write) begin
                req_cycles++;
                if (stall_cnt < wait_cycles) begin
                    av.i_AV_WaitRequest = 1'b1;
                    stall_cnt++;
                end else begin
                    av.i_AV_WaitRequest = 1'b0;
                    stall_cnt = 0;
                end
            end else begin
                av.i_AV_WaitRequest = 1'b0;
                stall_cnt = 0;
            end
            prev_stall = (av.o_AV_Read || av.o_AV_Write) && av.i_AV_WaitRequest;
            snap = {av.o_AV_Addr, av.o_AV_Read, av.o_AV_Write, av.o_AV_WriteData};
            if (av.o_AV_Read && !av.i_AV_WaitRequest) begin
                rd_q.push_back(av.o_AV_Addr);
                pend_d = mem_word(av.o_AV_Addr);
                pend_v = 1'b1;
            end
            if (av.o_AV_Write && !av.i_AV_WaitRequest)
                wr_q.push_back({av.o_AV_Addr, av.o_AV_WriteData});
        end
        if (busy) busy_cycles++;
        if (done) begin
            done_cycles++;
            if (done_at < 0) done_at = tb_cyc;
        end
    end

    task automatic clear_monitor();
        rd_q.delete();
        wr_q.delete();
        busy_cycles = 0;
        done_cycles = 0;
        done_at     = -1;
        req_cycles  = 0;
        stab_err    = 0;
        both_err    = 0;
    endtask

    // One complete copy, checked against the expected transfer list and timing.
    task automatic run_copy(input string name, input logic [29:0] s, input logic [29:0] d,
                            input logic [15:0] l, input int w, input int poke);
        logic [29:0] exp_rd[$];
        logic [61:0] exp_wr[$];
        int exp_lat, exp_busy, exp_req, start_cyc;
        logic ok;
        for (int k = 0; k < int'(l); k++) begin
            exp_rd.push_back(s + 30'(k));
            exp_wr.push_back({d + 30'(k), mem_word(s + 30'(k))});
        end
        exp_busy = (l == 16'd0) ? 1 : (3 + 2 * w) * int'(l);
        exp_lat  = (l == 16'd0) ? 2 : exp_busy + 1;
        exp_req  = 2 * int'(l) * (w + 1);

        @(negedge clk); #1;
        wait_cycles = w;
        clear_monitor();
        start  = 1'b1;
        src_in = s;
        dst_in = d;
        len_in = l;
        start_cyc = tb_cyc;
        for (int i = 0; i < 600 && done_at < 0; i++) begin
            @(negedge clk); #1;
            src_in = 30'($urandom());
            dst_in = 30'($urandom());
            len_in = 16'($urandom_range(1, 9));
            start  = (poke != 0 && i + 1 == poke) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
        end

        n_checks++;
        if (done_at < 0) begin
            n_fail++;
            $display("FAIL %s done_timeout: got no done pulse, required one", name);
        end else if ((done_at - start_cyc) !== exp_lat) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d, required %0d", name, done_at - start_cyc, exp_lat);
        end
        n_checks++;
        if (done_cycles !== 1) begin
            n_fail++;
            $display("FAIL %s done_width: got %0d cycles, required 1", name, done_cycles);
        end
        n_checks++;
        if (busy_cycles !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cycles, exp_busy);
        end
        n_checks++;
        if (req_cycles !== exp_req) begin
            n_fail++;
            $display("FAIL %s request_cycles: got %0d, required %0d", name, req_cycles, exp_req);
        end
        ok = (rd_q.size() == exp_rd.size());
        for (int k = 0; ok && k < exp_rd.size(); k++) if (rd_q[k] !== exp_rd[k]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s reads: got %0d reads first %h, required %0d reads first %h",
                     name, rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 30'd0,
                     exp_rd.size(), (exp_rd.size() > 0) ? exp_rd[0] : 30'd0);
        end
        ok = (wr_q.size() == exp_wr.size());
        for (int k = 0; ok && k < exp_wr.size(); k++) if (wr_q[k] !== exp_wr[k]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s writes: got %0d writes, required %0d", name, wr_q.size(), exp_wr.size());
            for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++)
                if (wr_q[k] !== exp_wr[k])
                    $display("FAIL %s write%0d: got addr %h data %h, required addr %h data %h", name, k,
                             wr_q[k][61:32], wr_q[k][31:0], exp_wr[k][61:32], exp_wr[k][31:0]);
        end
        n_checks++;
        if (stab_err !== 0 || both_err !== 0) begin
            n_fail++;
            $display("FAIL %s bus_rules: got %0d unstable stalls and %0d read+write cycles, required 0 and 0",
                     name, stab_err, both_err);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, av.o_AV_Read, av.o_AV_Write, av.o_AV_Addr, av.o_AV_WriteData} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, required all 0",
                     busy, done, av.o_AV_Read, av.o_AV_Write, av.o_AV_Addr, av.o_AV_WriteData);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_monitor();
        repeat (4) begin
            @(negedge clk); #1;
        end
        n_checks++;
        if (busy_cycles !== 0 || req_cycles !== 0 || done_cycles !== 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%0d req=%0d done=%0d cycles, required 0 0 0",
                     busy_cycles, req_cycles, done_cycles);
        end
    endtask

    task automatic test_reset_mid_copy();
        int req_base;
        logic seen_write = 1'b0;
        @(negedge clk); #1;
        wait_cycles = 0;
        clear_monitor();
        start  = 1'b1;
        src_in = 30'h40;
        dst_in = 30'h200;
        len_in = 16'd4;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !seen_write; i++) begin
            if (av.o_AV_Write) seen_write = 1'b1;
            else begin
                @(negedge clk); #1;
            end
        end
        n_checks++;
        if (!seen_write) begin
            n_fail++;
            $display("FAIL rst_mid_write_timeout: got no write phase, required one");
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, av.o_AV_Read, av.o_AV_Write, av.o_AV_Addr, av.o_AV_WriteData} !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, required all 0",
                     busy, done, av.o_AV_Read, av.o_AV_Write, av.o_AV_Addr, av.o_AV_WriteData);
        end
        req_base = req_cycles;
        repeat (3) begin
            @(negedge clk); #1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
        end
        n_checks++;
        if (done_cycles !== 0 || req_cycles !== req_base) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got done=%0d new_req=%0d, required 0 0",
                     done_cycles, req_cycles - req_base);
        end
        run_copy("rst_restart", 30'h40, 30'h200, 16'd4, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++)
            run_copy("random", 30'($urandom()), 30'($urandom()), 16'($urandom_range(1, 5)),
                     int'($urandom_range(0, 2)), 0);
    endtask

    initial begin
        av.i_AV_WaitRequest = 1'b0;
        av.i_AV_ReadData    = 32'd0;
        test_reset();
        run_copy("rom_copy", 30'd0, 30'h100, 16'd4, 0, 0);
        run_copy("zero_len", 30'h123, 30'h456, 16'd0, 0, 0);
        run_copy("wait_states", 30'h1000, 30'h2000, 16'd2, 3, 0);
        run_copy("addr_wrap", 30'h3FFFFFFF, 30'h3FFFFFFE, 16'd2, 0, 0);
        run_copy("start_while_busy", 30'h77, 30'h5000, 16'd3, 1, 4);
        test_reset_mid_copy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
